parity_arbiter: RTL and testbench
=================================

# parity_arbiter

Round-robin controller that shares one registered parity evaluator between two requesters. Each requester presents a WIDTH-bit word with a request. The block grants one requester at a time, latches its word, and computes even/odd parity. It returns the result tagged with the requester ID. It sits in front of the parity datapath, so the evaluator is never driven by two sources at once, and it keeps per-requester service counts for debug.

## Interface
- WIDTH, 3, data word width (>=1)
- CNT_W, 8, width of per-requester service counters
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req0  input  1  requester 0 request; held high until gnt0
- data0  input  WIDTH  requester 0 word; sampled on grant edge
- req1  input  1  requester 1 request; held high until gnt1
- data1  input  WIDTH  requester 1 word; sampled on grant edge
- gnt0  output  1  one-cycle grant pulse to requester 0
- gnt1  output  1  one-cycle grant pulse to requester 1
- busy  output  1  high while a request is in flight (state != IDLE)
- res_valid  output  1  one-cycle result strobe
- res_id  output  1  requester served by current/last result (0 or 1)
- even  output  1  1 when latched word has an even number of ones
- odd  output  1  1 when latched word has an odd number of ones
- cnt0  output  CNT_W  completed requests for requester 0, saturating
- cnt1  output  CNT_W  completed requests for requester 1, saturating

## Operation
- **States:** IDLE, EVAL, DONE; all outputs are registered.
- **IDLE:**
  - Any req high at a clock edge selects a winner.
  - The winner's data goes into the word register, and its gnt is set for one cycle.
  - The round-robin pointer `last` is set to the winner, and the state moves to EVAL.
  - With no request, the state stays in IDLE.
- **Arbitration:**
  - A single request wins.
  - If both requests are high, the requester not equal to `last` wins.
  - `last` resets to 1, so requester 0 wins the first simultaneous contest.
- **EVAL:**
  - even = XNOR-reduce(word); odd = XOR-reduce(word).
  - res_id = `last`, res_valid = 1, and the winner's counter increments unless it is at all-ones.
  - State moves to DONE.
- **DONE:** res_valid returns to 0 and the state moves to IDLE. No request is accepted on this edge.
- **Persistence:** even, odd and res_id hold their values until the next EVAL edge.
- **Exactly-one rule:** after the first result, exactly one of even/odd is high.
- **Requester protocol:**
  - A requester drops req in the cycle gnt is seen.
  - A req still high when the arbiter is next in IDLE counts as a new request.
  - req and data changes while busy are ignored; data is sampled only on the grant edge.
- **Reset (any state, including mid-operation):**
  - State goes to IDLE and `last` to 1.
  - gnt0, gnt1, busy, res_valid, res_id, even, odd, cnt0 and cnt1 all go to 0.
  - An in-flight request is dropped with no result; the requester must re-request.
- **Reset priority:** rst has priority over all other inputs on the same edge.

## Timing
- **Edge E0 (IDLE, req sampled high):** afterwards gnt=1, busy=1, state EVAL.
- **Edge E1:** afterwards gnt=0, res_valid=1, even/odd/res_id valid, count updated, busy=1.
- **Edge E2:** afterwards res_valid=0, busy=0, state IDLE.
- **Edge E3:** earliest edge at which the next request is granted.
- **Latency:** request to grant is 1 edge; request to result is 2 edges.
- **Throughput:** one request per 3 cycles, regardless of requester mix.
- **Fairness:** when both requesters are held high continuously, grants alternate 0,1,0,1,…
- **Reset exit:** the first edge after rst deasserts may grant.

## Test plan
- **Reset:** rst high 2 cycles with req0=req1=1 -> all outputs 0, no gnt during rst. After release: gnt0 on first edge, res_valid two edges later.
- **Single requester sweep:** req0 with data0 swept 000..111, one per 3 cycles -> even=1 for 000,011,101,110, odd=1 for 001,010,100,111. res_id=0 each time; cnt0 ends at 8.
- **Contention:** req0 and req1 held high for 12 cycles with data0=011, data1=111.
  - Grants alternate gnt0,gnt1,gnt0,gnt1.
  - Results alternate even(id0), odd(id1).
  - cnt0=2, cnt1=2.
- **Late data change:** data0=001 at grant, changed to 000 during EVAL -> result odd=1 (word latched at grant).
- **Mid-operation reset:** rst asserted in the EVAL cycle -> no res_valid; counters 0; busy=0 next cycle. Next req1 is granted 1 edge after rst drops.
- **Counter saturation:** CNT_W=2, 5 requests from req1 -> cnt1 reads 1,2,3,3,3.

Source files
------------

// File: rtl/parity_arbiter_if.sv
// parity_arbiter_if: request/grant/result bundle between two requesters
// and the shared parity evaluator.
//
// Ports (signals):
//   req0/req1     requester requests, held until the matching grant
//   data0/data1   requester words, sampled on the grant edge
//   gnt0/gnt1     one-cycle grant pulses
//   busy          a request is in flight
//   res_valid     one-cycle result strobe
//   res_id        requester served by the current/last result
//   even/odd      parity of the latched word
//   cnt0/cnt1     saturating per-requester service counts
//
// Modports: master drives requests (requester side), slave is the arbiter.
interface parity_arbiter_if #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
);
    logic             req0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             busy;
    logic             res_valid;
    logic             res_id;
    logic             even;
    logic             odd;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output req0, data0, req1, data1,
        input  gnt0, gnt1, busy, res_valid, res_id,
        input  even, odd, cnt0, cnt1
    );

    modport slave (
        input  req0, data0, req1, data1,
        output gnt0, gnt1, busy, res_valid, res_id,
        output even, odd, cnt0, cnt1
    );
endinterface

// File: rtl/parity_arbiter.sv
// parity_arbiter: round-robin share of one registered parity evaluator
// between two requesters, with tagged results and service counters.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   parity_arbiter_if.slave (requests in; grants, result, counts out)
module parity_arbiter #(
    parameter int WIDTH = 3,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    parity_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             busy_q, busy_d;
    logic             rv_q, rv_d;
    logic             rid_q, rid_d;
    logic             even_q, even_d;
    logic             odd_q, odd_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic any_req;
    logic win;

    // Winner: a lone request wins; on contention the side that was not
    // served last wins, which alternates grants under steady load.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            win = ~last_q;
        end else begin
            win = bus.req1;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        word_d  = word_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        rv_d    = 1'b0;
        rid_d   = rid_q;
        even_d  = even_q;
        odd_d   = odd_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    word_d  = win ? bus.data1 : bus.data0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    last_d  = win;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                even_d  = ~^word_q;
                odd_d   = ^word_q;
                rid_d   = last_q;
                rv_d    = 1'b1;
                state_d = DONE;
                if (last_q) begin
                    if (cnt1_q != CNT_MAX) begin
                        cnt1_d = cnt1_q + CNT_ONE;
                    end
                end else begin
                    if (cnt0_q != CNT_MAX) begin
                        cnt0_d = cnt0_q + CNT_ONE;
                    end
                end
            end
            DONE: begin
                // Dead cycle: no grant here, so a fresh grant comes
                // no sooner than three edges after the previous one.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            word_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
            rid_q   <= 1'b0;
            even_q  <= 1'b0;
            odd_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            word_q  <= word_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            busy_q  <= busy_d;
            rv_q    <= rv_d;
            rid_q   <= rid_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = rv_q;
    assign bus.res_id    = rid_q;
    assign bus.even      = even_q;
    assign bus.odd       = odd_q;
    assign bus.cnt0      = cnt0_q;
    assign bus.cnt1      = cnt1_q;
endmodule

// File: tb/tb_parity_arbiter.sv
// tb_parity_arbiter: directed and randomized checks of parity_arbiter
// against a cycle-number based reference model.
module tb_parity_arbiter;
    localparam int W  = 3;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    logic rst_s;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    parity_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    parity_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    parity_arbiter_if #(.WIDTH(W), .CNT_W(2)) sbus ();
    parity_arbiter #(.WIDTH(W), .CNT_W(2)) dut_s (
        .clk (clk),
        .rst (rst_s),
        .bus (sbus.slave)
    );

    function automatic logic podd(input logic [W-1:0] w);
        return ($countones(w) % 2) == 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.data0 = 3'b110;
        bus.data1 = 3'b111;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.busy, bus.res_valid} !== 4'b0) begin
                errors++;
                $display("FAIL reset_ctl cyc=%0d got=%b exp=0000", i,
                         {bus.gnt0, bus.gnt1, bus.busy, bus.res_valid});
            end
            checks++;
            if ({bus.res_id, bus.even, bus.odd, bus.cnt0, bus.cnt1} !== '0) begin
                errors++;
                $display("FAIL reset_res cyc=%0d id=%b ev=%b od=%b c0=%0d c1=%0d exp all 0",
                         i, bus.res_id, bus.even, bus.odd, bus.cnt0, bus.cnt1);
            end
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1, bus.busy} !== 3'b101) begin
            errors++;
            $display("FAIL reset_exit_gnt got g0g1b=%b exp=101",
                     {bus.gnt0, bus.gnt1, bus.busy});
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_id, bus.even, bus.odd} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_exit_res got rv,id,ev,od=%b exp=1010",
                     {bus.res_valid, bus.res_id, bus.even, bus.odd});
        end
        tick();
    endtask

    task automatic test_sweep();
        logic [W-1:0] v;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = W'(i);
            bus.req0 = 1'b1;
            bus.data0 = v;
            tick();
            checks++;
            if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
                errors++;
                $display("FAIL sweep_gnt v=%b got g0g1=%b exp=10", v,
                         {bus.gnt0, bus.gnt1});
            end
            bus.req0 = 1'b0;
            bus.data0 = W'($urandom);
            tick();
            checks++;
            if ({bus.res_valid, bus.res_id, bus.even, bus.odd} !==
                {1'b1, 1'b0, ~podd(v), podd(v)}) begin
                errors++;
                $display("FAIL sweep_res v=%b got rv,id,ev,od=%b exp=%b", v,
                         {bus.res_valid, bus.res_id, bus.even, bus.odd},
                         {1'b1, 1'b0, ~podd(v), podd(v)});
            end
            tick();
            checks++;
            if ({bus.busy, bus.res_valid} !== 2'b00) begin
                errors++;
                $display("FAIL sweep_idle v=%b got busy,rv=%b exp=00", v,
                         {bus.busy, bus.res_valid});
            end
        end
        checks++;
        if (bus.cnt0 !== CW'(8)) begin
            errors++;
            $display("FAIL sweep_cnt0 got=%0d exp=8", bus.cnt0);
        end
    endtask

    task automatic test_contention();
        logic exp_g0, exp_g1, exp_rv, id;
        logic [W-1:0] w;
        do_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.data0 = 3'b011;
        bus.data1 = 3'b111;
        for (int c = 0; c < 12; c++) begin
            id = ((c / 3) % 2) == 1;
            exp_g0 = (c % 3 == 0) && !id;
            exp_g1 = (c % 3 == 0) && id;
            exp_rv = (c % 3 == 1);
            w = id ? 3'b111 : 3'b011;
            tick();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.res_valid} !== {exp_g0, exp_g1, exp_rv}) begin
                errors++;
                $display("FAIL cont_ctl c=%0d got g0,g1,rv=%b exp=%b", c,
                         {bus.gnt0, bus.gnt1, bus.res_valid},
                         {exp_g0, exp_g1, exp_rv});
            end
            if (exp_rv) begin
                checks++;
                if ({bus.res_id, bus.even, bus.odd} !== {id, ~podd(w), podd(w)}) begin
                    errors++;
                    $display("FAIL cont_res c=%0d got id,ev,od=%b exp=%b", c,
                             {bus.res_id, bus.even, bus.odd},
                             {id, ~podd(w), podd(w)});
                end
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        checks++;
        if ({bus.cnt0, bus.cnt1} !== {CW'(2), CW'(2)}) begin
            errors++;
            $display("FAIL cont_cnt got c0=%0d c1=%0d exp 2/2", bus.cnt0, bus.cnt1);
        end
        tick();
        tick();
    endtask

    task automatic test_late_data();
        do_reset();
        bus.req0 = 1'b1;
        bus.data0 = 3'b001;
        tick();
        bus.req0 = 1'b0;
        bus.data0 = 3'b000;
        tick();
        checks++;
        if ({bus.res_valid, bus.even, bus.odd} !== 3'b101) begin
            errors++;
            $display("FAIL late_data got rv,ev,od=%b exp=101",
                     {bus.res_valid, bus.even, bus.odd});
        end
        tick();
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] d;
        do_reset();
        bus.req1 = 1'b1;
        bus.data1 = 3'b101;
        tick();
        checks++;
        if (bus.gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_gnt got=%b exp=1", bus.gnt1);
        end
        bus.req1 = 1'b0;
        rst = 1'b1;
        tick();
        checks++;
        if ({bus.res_valid, bus.busy, bus.cnt0, bus.cnt1} !== '0) begin
            errors++;
            $display("FAIL midrst_state got rv=%b busy=%b c0=%0d c1=%0d exp 0",
                     bus.res_valid, bus.busy, bus.cnt0, bus.cnt1);
        end
        rst = 1'b0;
        d = W'($urandom);
        bus.req1 = 1'b1;
        bus.data1 = d;
        tick();
        checks++;
        if ({bus.gnt0, bus.gnt1} !== 2'b01) begin
            errors++;
            $display("FAIL midrst_regnt got g0g1=%b exp=01", {bus.gnt0, bus.gnt1});
        end
        bus.req1 = 1'b0;
        tick();
        checks++;
        if ({bus.res_valid, bus.res_id, bus.even, bus.odd, bus.cnt1} !==
            {1'b1, 1'b1, ~podd(d), podd(d), CW'(1)}) begin
            errors++;
            $display("FAIL midrst_res got rv,id,ev,od=%b c1=%0d exp=%b c1=1",
                     {bus.res_valid, bus.res_id, bus.even, bus.odd}, bus.cnt1,
                     {1'b1, 1'b1, ~podd(d), podd(d)});
        end
        tick();
    endtask

    task automatic test_saturation();
        int exp_c;
        rst_s = 1'b1;
        tick();
        rst_s = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sbus.req1 = 1'b1;
            sbus.data1 = W'($urandom);
            tick();
            sbus.req1 = 1'b0;
            tick();
            exp_c = (k > 3) ? 3 : k;
            checks++;
            if ({sbus.res_valid, sbus.cnt1} !== {1'b1, 2'(exp_c)}) begin
                errors++;
                $display("FAIL sat_cnt1 k=%0d got rv=%b c1=%0d exp rv=1 c1=%0d",
                         k, sbus.res_valid, sbus.cnt1, exp_c);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int free_at, res_at, c0, c1;
        logic last, pend0, pend1, win, rid;
        logic eg0, eg1, erv, ebusy, eid, eev, eod;
        logic [W-1:0] rword;
        do_reset();
        free_at = 0;
        res_at = -1;
        last = 1'b1;
        c0 = 0;
        c1 = 0;
        pend0 = 1'b0;
        pend1 = 1'b0;
        rid = 1'b0;
        rword = '0;
        eid = 1'b0;
        eev = 1'b0;
        eod = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (!pend0 && $urandom_range(0, 9) < 4) begin
                pend0 = 1'b1;
                bus.req0 = 1'b1;
            end
            if (!pend1 && $urandom_range(0, 9) < 4) begin
                pend1 = 1'b1;
                bus.req1 = 1'b1;
            end
            if ($urandom_range(0, 2) == 0) bus.data0 = W'($urandom);
            if ($urandom_range(0, 2) == 0) bus.data1 = W'($urandom);
            eg0 = 1'b0;
            eg1 = 1'b0;
            erv = 1'b0;
            if (c == res_at) begin
                erv = 1'b1;
                eid = rid;
                eev = ~podd(rword);
                eod = podd(rword);
                if (rid) c1 = (c1 == 255) ? 255 : c1 + 1;
                else c0 = (c0 == 255) ? 255 : c0 + 1;
            end
            if (c >= free_at && (pend0 || pend1)) begin
                win = (pend0 && pend1) ? ~last : pend1;
                last = win;
                rid = win;
                rword = win ? bus.data1 : bus.data0;
                eg0 = ~win;
                eg1 = win;
                res_at = c + 1;
                free_at = c + 3;
            end
            ebusy = (c < free_at - 1);
            tick();
            checks++;
            if ({bus.gnt0, bus.gnt1, bus.res_valid, bus.busy} !==
                {eg0, eg1, erv, ebusy}) begin
                errors++;
                $display("FAIL rand_ctl c=%0d got g0,g1,rv,busy=%b exp=%b", c,
                         {bus.gnt0, bus.gnt1, bus.res_valid, bus.busy},
                         {eg0, eg1, erv, ebusy});
            end
            checks++;
            if ({bus.res_id, bus.even, bus.odd} !== {eid, eev, eod}) begin
                errors++;
                $display("FAIL rand_res c=%0d got id,ev,od=%b exp=%b", c,
                         {bus.res_id, bus.even, bus.odd}, {eid, eev, eod});
            end
            checks++;
            if ({bus.cnt0, bus.cnt1} !== {CW'(c0), CW'(c1)}) begin
                errors++;
                $display("FAIL rand_cnt c=%0d got c0=%0d c1=%0d exp c0=%0d c1=%0d",
                         c, bus.cnt0, bus.cnt1, c0, c1);
            end
            if (eg0) begin
                pend0 = 1'b0;
                bus.req0 = 1'b0;
            end
            if (eg1) begin
                pend1 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;
        sbus.req0 = 1'b0;
        sbus.req1 = 1'b0;
        sbus.data0 = '0;
        sbus.data1 = '0;
        test_reset();
        test_sweep();
        test_contention();
        test_late_data();
        test_mid_reset();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
